// File: rtl/count_enable_scheduler_pkg.sv
// Shared encodings and defaults for the counter-enable scheduler
// and any arbiter built on rr_pick.
package count_sched_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int NREQ_DEF = 4;
  localparam int LW_DEF   = 4;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_enable_scheduler_rr_pick.sv
// Round-robin winner select: first set request at or after ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_pick
  import count_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_win,
  output logic            o_valid
);

  always_comb begin : p_pick
    int j;
    logic [PW-1:0] w_idx;
    j       = 0;
    w_idx   = '0;
    o_win   = '0;
    o_valid = |i_req;
    // Scan downward so the closest index to ptr is written last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(i_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      w_idx = PW'(j);
      if (i_req[w_idx]) o_win = w_idx;
    end
  end

endmodule

// File: rtl/count_enable_scheduler.sv
// Moore controller granting one requester at a time the shared
// mod-4 counter enable for a sampled number of cycles.
module count_enable_scheduler
  import count_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LW   = LW_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*LW-1:0] len,
  input  logic               y_in,
  output logic               x_out,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               done,
  output logic               hit
);

  localparam int PW = ptr_w(NREQ);

  logic [1:0]      r_state;
  logic [NREQ-1:0] r_grant;
  logic [LW-1:0]   r_rem;
  logic            r_hit;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;

  logic [PW-1:0]   w_win;
  logic            w_valid;
  logic [LW-1:0]   w_len;
  logic [NREQ-1:0] w_onehot;
  logic [PW-1:0]   w_ptr_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  assign w_len = len[int'(w_win)*LW +: LW];

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
  end

  assign w_ptr_nxt = (int'(r_win) == NREQ - 1) ? '0
                   : r_win + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rem   <= '0;
      r_hit   <= 1'b0;
      r_ptr   <= '0;
      r_win   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant <= w_onehot;
            r_win   <= w_win;
            r_rem   <= w_len;
            r_hit   <= 1'b0;
            r_state <= (w_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          r_rem <= r_rem - 1'b1;
          r_hit <= r_hit | y_in;
          // remaining==0 cannot occur here; treat it as last cycle anyway
          if (r_rem <= LW'(1)) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_ptr   <= w_ptr_nxt;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign x_out = (r_state == RUN);
  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign hit   = (r_state == DONE) & r_hit;
  assign grant = r_grant;

endmodule

// File: tb/tb_count_enable_scheduler.sv
// Directed vector bench for count_enable_scheduler with a mod-4
// counter model closing the x_out -> y_in loop.
module tb_count_enable_scheduler;

  localparam int NREQ = 4;
  localparam int LW   = 4;

  logic               clock;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*LW-1:0] len;
  logic               y_in;
  logic               x_out;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               done;
  logic               hit;

  logic [1:0] cnt;

  int checks;
  int failures;

  count_enable_scheduler #(
    .NREQ (NREQ),
    .LW   (LW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .len   (len),
    .y_in  (y_in),
    .x_out (x_out),
    .grant (grant),
    .busy  (busy),
    .done  (done),
    .hit   (hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // shared mod-4 counter datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= 2'd0;
    else if (x_out) cnt <= cnt + 2'd1;
  end
  assign y_in = (cnt == 2'd3);

  typedef struct {
    bit          rst;
    logic [3:0]  rq;
    logic [15:0] ln;
    logic        x;
    logic [3:0]  g;
    logic        b;
    logic        d;
    logic        h;
    bit          cc;
    logic [1:0]  c;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input bit rst, input logic [3:0] rq, input logic [15:0] ln,
    input logic x, input logic [3:0] g, input logic b,
    input logic d, input logic h, input bit cc, input logic [1:0] c);
    vec_t r;
    r.rst = rst; r.rq = rq; r.ln = ln;
    r.x = x; r.g = g; r.b = b; r.d = d; r.h = h;
    r.cc = cc; r.c = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int xc;
    int dc;
    logic [7:0] o;
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    req   = '0;
    len   = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {x_out, grant, busy, done, hit}, 8'h00);
    reset = 1'b0;

    // 1: len0=3
    tv.push_back(v(1, 4'b0001, 16'h0003, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0003, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0003, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0003, 0, 4'b0001, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0003, 0, 4'b0000, 0, 0, 0, 1, 3));
    // 2: len0=5, counter passes S3
    tv.push_back(v(1, 4'b0001, 16'h0005, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0005, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0005, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0005, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0005, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0005, 0, 4'b0001, 1, 1, 1, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h0005, 0, 4'b0000, 0, 0, 0, 1, 1));
    // 3: all requesting, len=1
    tv.push_back(v(1, 4'b1111, 16'h1111, 1, 4'b0001, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b0001, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b0000, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 1, 4'b0010, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b0010, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b0000, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 1, 4'b0100, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b0100, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b0000, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 1, 4'b1000, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b1000, 1, 1, 1, 0, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 0, 4'b0000, 0, 0, 0, 1, 0));
    tv.push_back(v(0, 4'b1111, 16'h1111, 1, 4'b0001, 1, 0, 0, 0, 0));
    // 4: len2=0, then ptr must sit at 3
    tv.push_back(v(1, 4'b0100, 16'h1011, 0, 4'b0100, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h1011, 0, 4'b0000, 0, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b1101, 16'h1111, 1, 4'b1000, 1, 0, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h1111, 0, 4'b1000, 1, 1, 0, 0, 0));
    tv.push_back(v(0, 4'b0000, 16'h1111, 0, 4'b0000, 0, 0, 0, 0, 0));

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      req = tv[i].rq;
      len = tv[i].ln;
      step();
      o = {tv[i].x, tv[i].g, tv[i].b, tv[i].d, tv[i].h};
      chk($sformatf("vec%0d", i), {x_out, grant, busy, done, hit}, o);
      if (tv[i].cc) chk($sformatf("vec%0d_cnt", i), cnt, tv[i].c);
    end

    // 5: move ptr to 2, then reset mid-burst
    req = 4'b0010;
    len = 16'h0010;
    step();
    chk("t5_grant1", grant, 4'b0010);
    req = 4'b0000;
    step();
    step();
    req = 4'b0001;
    len = 16'h0007;
    step();
    chk("t5_grant0", grant, 4'b0001);
    req = 4'b0000;
    step();
    step();
    chk("t5_running", x_out, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_x", x_out, 1'b0);
    chk("t5_async_grant", grant, 4'b0000);
    chk("t5_async_busy", busy, 1'b0);
    reset = 1'b0;
    dc = 0;
    repeat (4) begin
      step();
      if (done) dc++;
    end
    chk("t5_no_done", dc, 0);
    req = 4'b1010;
    len = 16'h1111;
    step();
    chk("t5_ptr_reset", grant, 4'b0010);

    // 6: len changed mid-burst
    do_reset();
    req = 4'b0001;
    len = 16'h0002;
    xc = 0;
    dc = 0;
    step();
    if (x_out) xc++;
    len = 16'h0009;
    req = 4'b0000;
    repeat (12) begin
      step();
      if (x_out) xc++;
      if (done) dc++;
    end
    chk("t6_x_cycles", xc, 2);
    chk("t6_done_count", dc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
